// File: rtl/prep_acc_multi.sv
// Multi-channel block accumulator: channel-tagged samples are summed per channel and dumped every DEPTH samples.
// Optional build macro PREP_ACC_SAT_EN: clamp the block sum at 2^ACC_WIDTH-1 instead of wrapping.
module prep_acc_multi #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 16,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_ch,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_ch,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf
);

  localparam int CNTW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEPTH - 1);

  logic [ACC_WIDTH-1:0] acc_q [CHANNELS];
  logic [ACC_WIDTH-1:0] acc_d [CHANNELS];
  logic [CNTW-1:0]      cnt_q [CHANNELS];
  logic [CNTW-1:0]      cnt_d [CHANNELS];
  logic [CHANNELS-1:0]  ovf_q, ovf_d;

  logic                 out_valid_q, out_valid_d;
  logic [CW-1:0]        out_ch_q, out_ch_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_ovf_q, out_ovf_d;

  logic                 accept;
  logic                 ch_ok;
  logic [CW-1:0]        sel;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 carry;
  logic [ACC_WIDTH-1:0] sum;
  logic                 last;

  // Accept only while the output slot is free or draining this cycle; clr stalls the input.
  assign in_ready = !clr && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign ch_ok    = {1'b0, in_ch} < (CW + 1)'(CHANNELS);
  assign sel      = ch_ok ? in_ch : '0;
  assign sum_ext  = {1'b0, acc_q[sel]} + (ACC_WIDTH + 1)'(in_data);
  assign carry    = sum_ext[ACC_WIDTH];
`ifdef PREP_ACC_SAT_EN
  assign sum      = carry ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
  assign sum      = sum_ext[ACC_WIDTH-1:0];
`endif
  assign last     = (cnt_q[sel] == CNT_LAST);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
      ovf_d = '0;
    end else if (accept && ch_ok) begin
      if (last) begin
        acc_d[sel]  = '0;
        cnt_d[sel]  = '0;
        ovf_d[sel]  = 1'b0;
        out_valid_d = 1'b1;
        out_ch_d    = sel;
        out_data_d  = sum;
        out_ovf_d   = ovf_q[sel] | carry;
      end else begin
        acc_d[sel]  = sum;
        cnt_d[sel]  = cnt_q[sel] + 1'b1;
        ovf_d[sel]  = ovf_q[sel] | carry;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_prep_acc_multi.sv
// Bench for prep_acc_multi: default instance checked against a block-sum model, plus a
// narrow 3-channel instance (wrap/saturate, invalid channel) and a DEPTH=1 instance (vector table).
module tb_prep_acc_multi;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Instance A: default parameters
  logic        a_clr = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [1:0]  a_in_ch = '0;
  logic [15:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [1:0]  a_out_ch;
  logic [23:0] a_out_data;

  prep_acc_multi u_a (
    .CLK(CLK), .RST(RST), .clr(a_clr),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ch(a_in_ch), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ch(a_out_ch),
    .out_data(a_out_data), .out_ovf(a_out_ovf)
  );

  // Instance B: 16-bit accumulator, 3 channels (channel 3 is out of range)
  logic        b_clr = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [1:0]  b_in_ch = '0;
  logic [15:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [1:0]  b_out_ch;
  logic [15:0] b_out_data;

  prep_acc_multi #(.WIDTH(16), .ACC_WIDTH(16), .CHANNELS(3), .DEPTH(16)) u_b (
    .CLK(CLK), .RST(RST), .clr(b_clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ch(b_in_ch), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ch(b_out_ch),
    .out_data(b_out_data), .out_ovf(b_out_ovf)
  );

  // Instance C: every sample dumps directly
  logic        c_clr = 1'b0, c_in_valid = 1'b0, c_out_ready = 1'b0;
  logic [0:0]  c_in_ch = '0;
  logic [15:0] c_in_data = '0;
  logic        c_in_ready, c_out_valid, c_out_ovf;
  logic [0:0]  c_out_ch;
  logic [23:0] c_out_data;

  prep_acc_multi #(.WIDTH(16), .ACC_WIDTH(24), .CHANNELS(2), .DEPTH(1)) u_c (
    .CLK(CLK), .RST(RST), .clr(c_clr),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_ch(c_in_ch), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ch(c_out_ch),
    .out_data(c_out_data), .out_ovf(c_out_ovf)
  );

  // Block-sum model for instance A: samples are queued per channel and summed when a block completes
  logic [15:0] blk_q [4][$];
  logic        exp_ov = 1'b0;
  logic [1:0]  exp_och = '0;
  logic [23:0] exp_odata = '0;
  logic        exp_oovf = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) blk_q[i].delete();
    exp_ov    = 1'b0;
    exp_och   = '0;
    exp_odata = '0;
    exp_oovf  = 1'b0;
  endtask

  task automatic modelBlockDone(input int ch);
    longint total = 0;
    foreach (blk_q[ch][i]) total += longint'(blk_q[ch][i]);
    exp_ov   = 1'b1;
    exp_och  = 2'(ch);
    exp_oovf = (total >= (longint'(1) << 24));
`ifdef PREP_ACC_SAT_EN
    exp_odata = exp_oovf ? 24'hFFFFFF : total[23:0];
`else
    exp_odata = total[23:0];
`endif
    blk_q[ch].delete();
  endtask

  // One clock of instance A: drive, check in_ready against the model, clock, check outputs
  task automatic applyStimulus(input logic v, input logic [1:0] ch, input logic [15:0] d,
                               input logic ordy, input logic c);
    logic exp_rdy;
    @(negedge CLK);
    a_in_valid  = v;
    a_in_ch     = ch;
    a_in_data   = d;
    a_out_ready = ordy;
    a_clr       = c;
    #1;
    exp_rdy = !c && (!exp_ov || ordy);
    checkOutput("a_in_ready", 32'(a_in_ready), 32'(exp_rdy));
    @(posedge CLK);
    if (exp_ov && ordy) exp_ov = 1'b0;
    if (c) begin
      for (int i = 0; i < 4; i++) blk_q[i].delete();
    end else if (v && exp_rdy) begin
      blk_q[ch].push_back(d);
      if (blk_q[ch].size() == 16) modelBlockDone(int'(ch));
    end
    #1;
    checkOutput("a_out_valid", 32'(a_out_valid), 32'(exp_ov));
    if (exp_ov) begin
      checkOutput("a_out_ch", 32'(a_out_ch), 32'(exp_och));
      checkOutput("a_out_data", 32'(a_out_data), 32'(exp_odata));
      checkOutput("a_out_ovf", 32'(a_out_ovf), 32'(exp_oovf));
    end
  endtask

  task automatic driveB(input logic v, input logic [1:0] ch, input logic [15:0] d);
    @(negedge CLK);
    b_in_valid = v;
    b_in_ch    = ch;
    b_in_data  = d;
    #1;
    checkOutput("b_in_ready", 32'(b_in_ready), 32'd1);
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [0:0]  ch;
    logic [15:0] d;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_ov;
    logic [0:0]  exp_ch;
    logic [23:0] exp_data;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [15:0] b_exp;

    tbl[0] = '{1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 24'h001234};
    tbl[1] = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 24'h00FFFF};
    tbl[2] = '{1'b1, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b1, 24'h00FFFF};
    tbl[3] = '{1'b1, 1'b0, 16'h0007, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000007};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};
    tbl[5] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

    // Reset state
    #12;
    checkOutput("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    checkOutput("rst_a_out_data", 32'(a_out_data), 32'd0);
    checkOutput("rst_a_out_ch", 32'(a_out_ch), 32'd0);
    checkOutput("rst_a_out_ovf", 32'(a_out_ovf), 32'd0);
    checkOutput("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    checkOutput("rst_c_out_valid", 32'(c_out_valid), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    modelReset();

    // DEPTH=1 instance driven from the vector table
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      c_in_valid  = tbl[i].v;
      c_in_ch     = tbl[i].ch;
      c_in_data   = tbl[i].d;
      c_out_ready = tbl[i].ordy;
      #1;
      checkOutput("c_in_ready", 32'(c_in_ready), 32'(tbl[i].exp_rdy));
      @(posedge CLK);
      #1;
      checkOutput("c_out_valid", 32'(c_out_valid), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) begin
        checkOutput("c_out_ch", 32'(c_out_ch), 32'(tbl[i].exp_ch));
        checkOutput("c_out_data", 32'(c_out_data), 32'(tbl[i].exp_data));
        checkOutput("c_out_ovf", 32'(c_out_ovf), 32'd0);
      end
    end

    // 16-bit accumulator overflow on ch2, with out-of-range ch3 samples discarded
`ifdef PREP_ACC_SAT_EN
    b_exp = 16'hFFFF;
`else
    b_exp = 16'h0000;
`endif
    for (int i = 0; i < 16; i++) begin
      if (i == 3 || i == 7 || i == 11) begin
        driveB(1'b1, 2'd3, 16'hFFFF);
        checkOutput("b_discard_no_dump", 32'(b_out_valid), 32'd0);
      end
      driveB(1'b1, 2'd2, 16'h2000);
    end
    checkOutput("b_wrap_valid", 32'(b_out_valid), 32'd1);
    checkOutput("b_wrap_ch", 32'(b_out_ch), 32'd2);
    checkOutput("b_wrap_data", 32'(b_out_data), 32'(b_exp));
    checkOutput("b_wrap_ovf", 32'(b_out_ovf), 32'd1);
    for (int i = 0; i < 16; i++) driveB(1'b1, 2'd2, 16'h0001);
    checkOutput("b_after_wrap_data", 32'(b_out_data), 32'h10);
    checkOutput("b_after_wrap_ovf", 32'(b_out_ovf), 32'd0);
    driveB(1'b0, 2'd0, 16'h0000);

    // Single block on ch0
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd0, 16'h0001, 1'b1, 1'b0);
    checkOutput("t1_data", 32'(a_out_data), 32'h10);
    checkOutput("t1_ch", 32'(a_out_ch), 32'd0);
    applyStimulus(1'b0, 2'd0, 16'h0000, 1'b1, 1'b0);

    // Interleaved ch1/ch2 blocks, dumped back to back
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 2'd1, 16'h0100, 1'b1, 1'b0);
      if (i == 15) begin
        checkOutput("t2_ch1_ch", 32'(a_out_ch), 32'd1);
        checkOutput("t2_ch1_data", 32'(a_out_data), 32'h001000);
      end
      applyStimulus(1'b1, 2'd2, 16'hFFFF, 1'b1, 1'b0);
      if (i == 15) begin
        checkOutput("t2_ch2_ch", 32'(a_out_ch), 32'd2);
        checkOutput("t2_ch2_data", 32'(a_out_data), 32'h0FFFF0);
        checkOutput("t2_ch2_ovf", 32'(a_out_ovf), 32'd0);
      end
    end
    applyStimulus(1'b0, 2'd0, 16'h0000, 1'b1, 1'b0);

    // Output stall blocks input; release accepts in the same cycle
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd0, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd1, 16'h0005, 1'b0, 1'b0);
      checkOutput("t4_stall_data", 32'(a_out_data), 32'h10);
      checkOutput("t4_stall_valid", 32'(a_out_valid), 32'd1);
    end
    applyStimulus(1'b1, 2'd1, 16'h0005, 1'b1, 1'b0);

    // Clear mid-block discards the partial sum
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'd0, 16'h0005, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, 16'h0005, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd0, 16'h0001, 1'b1, 1'b0);
    checkOutput("t5_data", 32'(a_out_data), 32'h10);
    checkOutput("t5_ovf", 32'(a_out_ovf), 32'd0);

    // Asynchronous reset with partial ch2 block and a pending dump
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'd2, 16'h0002, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd0, 16'h0001, 1'b0, 1'b0);
    #1;
    RST = 1'b1;
    #1;
    checkOutput("t6_rst_valid", 32'(a_out_valid), 32'd0);
    checkOutput("t6_rst_data", 32'(a_out_data), 32'd0);
    checkOutput("t6_rst_ch", 32'(a_out_ch), 32'd0);
    checkOutput("t6_rst_ovf", 32'(a_out_ovf), 32'd0);
    modelReset();
    #1;
    RST = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd2, 16'h0002, 1'b1, 1'b0);
    checkOutput("t6_data", 32'(a_out_data), 32'h20);
    checkOutput("t6_ch", 32'(a_out_ch), 32'd2);

    // Randomized traffic against the block-sum model
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] d;
      int sel;
      sel = int'($urandom_range(0, 3));
      d = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'($urandom) : 16'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), d,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
